// File: rtl/push_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// FSM state encoding and synchronizer depth used by every channel.
package push_debounce_pkg;

  typedef enum logic [1:0] {
    StRel      = 2'd0,
    StPressChk = 2'd1,
    StPrs      = 2'd2,
    StRelChk   = 2'd3
  } state_e;

  localparam int unsigned SyncDepth = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/push_debounce_if.sv
// Button bundle between the raw pins and the debounced consumer.
// slave = debouncer side, master = pin driver / consumer side.
interface push_debounce_if #(
  parameter int unsigned NUM_BTN = 2
) ();

  logic [NUM_BTN-1:0] i_Push;
  logic [NUM_BTN-1:0] o_Level;
  logic [NUM_BTN-1:0] o_PressPulse;
  logic [NUM_BTN-1:0] o_RelPulse;
  logic [NUM_BTN-1:0] o_Busy;

  modport master (
    output i_Push,
    input  o_Level,
    input  o_PressPulse,
    input  o_RelPulse,
    input  o_Busy
  );

  modport slave (
    input  i_Push,
    output o_Level,
    output o_PressPulse,
    output o_RelPulse,
    output o_Busy
  );

endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: synchronizer, 4-state accept FSM, stability counter.
// Auto-repeat pulses are built only when PUSH_DEBOUNCE_AUTO_REPEAT_EN is defined.
module debounce_ch
  import push_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = 250000,
  parameter int unsigned CNT_W         = 18
`ifdef PUSH_DEBOUNCE_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
`endif
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic push_i,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYC);

  logic [SyncDepth-1:0] sync_q, sync_d;
  logic                 s_push;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 rel_q, rel_d;
  logic                 busy_q, busy_d;
  logic                 fsm_press;
  logic                 rpt_pulse;

  assign sync_d = {sync_q[SyncDepth-2:0], push_i};
  assign s_push = sync_q[SyncDepth-1];

  // Leaving a CHK state needs cnt == DEBOUNCE_CYC plus one more agreeing sample,
  // which gives DEBOUNCE_CYC + 2 edges from pin change to registered output.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fsm_press = 1'b0;
    rel_d     = 1'b0;
    unique case (state_q)
      StRel: begin
        if (s_push) begin
          state_d = StPressChk;
          cnt_d   = CNT_W'(1);
        end
      end
      StPressChk: begin
        if (!s_push) begin
          state_d = StRel;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d   = StPrs;
          cnt_d     = '0;
          fsm_press = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPrs: begin
        if (!s_push) begin
          state_d = StRelChk;
          cnt_d   = CNT_W'(1);
        end
      end
      StRelChk: begin
        if (s_push) begin
          state_d = StPrs;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StRel;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StRel;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef PUSH_DEBOUNCE_AUTO_REPEAT_EN
  localparam int unsigned RptW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [RptW-1:0] rpt_q, rpt_d, rpt_lim;
  logic            first_q, first_d;

  // Counter only runs while the channel stays in PRS; any exit or re-entry restarts the delay.
  always_comb begin
    rpt_d     = rpt_q;
    first_d   = first_q;
    rpt_pulse = 1'b0;
    rpt_lim   = first_q ? RptW'(REPEAT_DELAY - 1) : RptW'(REPEAT_PERIOD - 1);
    if (state_q != StPrs || state_d != StPrs) begin
      rpt_d   = '0;
      first_d = 1'b1;
    end else if (rpt_q == rpt_lim) begin
      rpt_pulse = 1'b1;
      rpt_d     = '0;
      first_d   = 1'b0;
    end else begin
      rpt_d = rpt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rpt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end
`else
  assign rpt_pulse = 1'b0;
`endif

  always_comb begin
    press_d = fsm_press | rpt_pulse;
    level_d = (state_d == StPrs) || (state_d == StRelChk);
    busy_d  = (state_d == StPressChk) || (state_d == StRelChk);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_q  <= '0;
      state_q <= StRel;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      busy_q  <= busy_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/push_debounce.sv
// Multi-channel push-button conditioner: polarity normalization plus one debounce_ch per pin.
// Optional auto-repeat is enabled by defining PUSH_DEBOUNCE_AUTO_REPEAT_EN.
module push_debounce
  import push_debounce_pkg::*;
#(
  parameter int unsigned NUM_BTN       = 2,
  parameter int unsigned DEBOUNCE_CYC  = 250000,
  parameter int unsigned CNT_W         = 18,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input logic            i_Clk,
  input logic            i_Rst,
  push_debounce_if.slave bus
);

  if (DEBOUNCE_CYC < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYC)) begin : g_bad_cnt
    $error("push_debounce: need DEBOUNCE_CYC >= 2 and 2**CNT_W > DEBOUNCE_CYC");
  end
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_rpt
    $error("push_debounce: REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
  end

  logic [NUM_BTN-1:0] push_norm;
  logic [NUM_BTN-1:0] level, press, rel, busy;

  // Inverting ahead of the synchronizer lets every flop reset to 0 = released.
  assign push_norm = ACTIVE_LOW ? ~bus.i_Push : bus.i_Push;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
`ifdef PUSH_DEBOUNCE_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_ch (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .push_i (push_norm[g]),
      .level_o(level[g]),
      .press_o(press[g]),
      .rel_o  (rel[g]),
      .busy_o (busy[g])
    );
  end

  assign bus.o_Level      = level;
  assign bus.o_PressPulse = press;
  assign bus.o_RelPulse   = rel;
  assign bus.o_Busy       = busy;

endmodule

// File: tb/tb_push_debounce.sv
// Scoreboard bench for push_debounce: a run-length reference model queues the expected
// outputs per edge and a negedge monitor pops and compares them.
module tb_push_debounce;

  localparam int DEB    = 4;
  localparam int RDELAY = 10;
  localparam int RPER   = 3;
`ifdef PUSH_DEBOUNCE_AUTO_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  push_debounce_if #(.NUM_BTN(2)) bus ();

  push_debounce #(
    .NUM_BTN      (2),
    .DEBOUNCE_CYC (DEB),
    .CNT_W        (3),
    .ACTIVE_LOW   (1'b1),
    .REPEAT_DELAY (RDELAY),
    .REPEAT_PERIOD(RPER)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a change is accepted once DEB+1 consecutive synchronized samples
  // disagree with the current level; samples reach the decision two edges after the pin.
  exp_t       sb_q[$];
  logic [1:0] sy1, sy2, s_now, norm;
  bit         lvl[2];
  int         run[2];
  int         hold_t[2];
  int         prev_run;
  exp_t       e;

  always @(posedge clk) begin
    e    = '0;
    norm = ~bus.i_Push;
    if (rst) begin
      sy1 = '0;
      sy2 = '0;
      for (int c = 0; c < 2; c++) begin
        lvl[c]    = 1'b0;
        run[c]    = 0;
        hold_t[c] = 0;
      end
    end else begin
      s_now = sy2;
      sy2   = sy1;
      sy1   = norm;
      for (int c = 0; c < 2; c++) begin
        prev_run = run[c];
        if (s_now[c] != lvl[c]) run[c]++;
        else run[c] = 0;
        if (run[c] == DEB + 1) begin
          lvl[c]    = ~lvl[c];
          run[c]    = 0;
          hold_t[c] = 0;
          if (lvl[c]) e.press[c] = 1'b1;
          else e.rel[c] = 1'b1;
        end else if (lvl[c] && run[c] == 0) begin
          if (prev_run > 0) begin
            hold_t[c] = 0;
          end else begin
            hold_t[c]++;
            if (RPT_EN && (hold_t[c] == RDELAY ||
                           (hold_t[c] > RDELAY && (hold_t[c] - RDELAY) % RPER == 0)))
              e.press[c] = 1'b1;
          end
        end
        e.level[c] = lvl[c];
        e.busy[c]  = (run[c] != 0);
      end
    end
    sb_q.push_back(e);
  end

  task automatic cmp(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty at %0t: got=0 entries expected>=1", $time);
    end else begin
      x = sb_q.pop_front();
      cmp("level", bus.o_Level, x.level);
      cmp("press_pulse", bus.o_PressPulse, x.press);
      cmp("rel_pulse", bus.o_RelPulse, x.rel);
      cmp("busy", bus.o_Busy, x.busy);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    bus.i_Push = 2'b11;
    rst        = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(5);

    // Reset in the middle of a press check must abort silently.
    bus.i_Push = 2'b10;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    bus.i_Push = 2'b11;
    rst        = 1'b0;
    cyc(6);

    // Clean press and release on ch0.
    bus.i_Push = 2'b10;
    cyc(12);
    bus.i_Push = 2'b11;
    cyc(12);

    // Bouncing ch1, then a stable press and release.
    for (int i = 0; i < 10; i++) begin
      bus.i_Push[1] = ~bus.i_Push[1];
      cyc(2);
    end
    bus.i_Push[1] = 1'b0;
    cyc(12);
    bus.i_Push[1] = 1'b1;
    cyc(12);

    // Three-cycle release glitch while ch0 is held.
    bus.i_Push = 2'b10;
    cyc(10);
    bus.i_Push = 2'b11;
    cyc(3);
    bus.i_Push = 2'b10;
    cyc(10);
    bus.i_Push = 2'b11;
    cyc(12);

    // Simultaneous press on both channels.
    bus.i_Push = 2'b00;
    cyc(10);
    bus.i_Push = 2'b11;
    cyc(12);

    // Long hold on ch0 to expose auto-repeat behaviour.
    bus.i_Push = 2'b10;
    cyc(6 + 30);
    bus.i_Push = 2'b11;
    cyc(12);

    // Random pin activity with occasional resets.
    for (int i = 0; i < 300; i++) begin
      bus.i_Push = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc($urandom_range(1, 8));
    end
    bus.i_Push = 2'b11;
    cyc(20);

    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got=%0d pending expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
